axi4_lite_slave_regfile: RTL and testbench

//  AXI4-Lite slave terminating the axi4_lite_master bus: NUM_REGS word-wide R/W registers, byte strobes,

---
 rtl/axi4_lite_slave_regfile_pkg.sv | 11 +
 rtl/axi4_lite_addr_decode.sv | 22 ++
 rtl/axi4_lite_slave_regfile.sv | 114 +++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_slave_regfile_pkg.sv
// axi4_lite_slave_regfile_pkg: shared AXI4-Lite response codes, PROT width and register-index width helper.
package axi4_lite_slave_regfile_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int PROT_W = 3;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi4_lite_addr_decode.sv
// axi4_lite_addr_decode: byte address -> register index and in-range flag (combinational).
// Ports: addr (byte address), idx (word index relative to BASE_ADDR), in_range (BASE_ADDR <= addr, idx < NUM_REGS).
module axi4_lite_addr_decode
  import axi4_lite_slave_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int IW = idx_w(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IW-1:0]         idx,
  output logic                  in_range
);
  localparam int SH = $clog2(DATA_WIDTH / 8);
  logic [ADDR_WIDTH-1:0] word;
  // sub-word address bits fall away in the shift
  assign word = (addr - BASE_ADDR) >> SH;
  assign in_range = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS));
  assign idx = word[IW-1:0];
endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile: AXI4-Lite slave with NUM_REGS word registers, byte strobes, SLVERR when out of range.
// Ports: iCLK, iRST (async active-low); AXI4-Lite slave channels s_AW*, s_W*, s_B*, s_AR*, s_R*;
//   regs_out flat export (register i at [i*DATA_WIDTH +: DATA_WIDTH]).
// Option AXI4_LITE_REGFILE_WR_PULSE_EN: adds wr_pulse[NUM_REGS-1:0], one cycle high per OKAY commit to that index.
module axi4_lite_slave_regfile
  import axi4_lite_slave_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           iCLK,
  input  logic                           iRST,
  input  logic                           s_AWVALID,
  output logic                           s_AWREADY,
  input  logic [ADDR_WIDTH-1:0]          s_AWADDR,
  input  logic [PROT_W-1:0]              s_AWPROT,
  input  logic                           s_WVALID,
  output logic                           s_WREADY,
  input  logic [DATA_WIDTH-1:0]          s_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        s_WSTRB,
  output logic                           s_BVALID,
  input  logic                           s_BREADY,
  output logic [1:0]                     s_BRESP,
  input  logic                           s_ARVALID,
  output logic                           s_ARREADY,
  input  logic [ADDR_WIDTH-1:0]          s_ARADDR,
  input  logic [PROT_W-1:0]              s_ARPROT,
  output logic                           s_RVALID,
  input  logic                           s_RREADY,
  output logic [DATA_WIDTH-1:0]          s_RDATA,
  output logic [1:0]                     s_RRESP,
`ifdef AXI4_LITE_REGFILE_WR_PULSE_EN
  output logic [NUM_REGS-1:0]            wr_pulse,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = idx_w(NUM_REGS);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IW-1:0] wa_idx, ra_idx, aw_idx;
  logic wa_ok, ra_ok, aw_ok, aw_full, w_full, aw_nxt, w_nxt, commit;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic unused;
  assign unused = ^{s_AWPROT, s_ARPROT};
  axi4_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR))
    u_aw_dec (.addr(s_AWADDR), .idx(wa_idx), .in_range(wa_ok));
  axi4_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR))
    u_ar_dec (.addr(s_ARADDR), .idx(ra_idx), .in_range(ra_ok));
  // a commit needs both stages filled and no response still waiting for BREADY
  assign commit = aw_full & w_full & ~s_BVALID;
  assign aw_nxt = ~commit & (aw_full | (s_AWVALID & s_AWREADY));
  assign w_nxt  = ~commit & (w_full | (s_WVALID & s_WREADY));
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      s_AWREADY <= 1'b0;
      s_WREADY  <= 1'b0;
      s_BVALID  <= 1'b0;
      s_BRESP   <= RESP_OKAY;
      aw_idx    <= '0;
      aw_ok     <= 1'b0;
      w_data    <= '0;
      w_strb    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      aw_full   <= aw_nxt;
      w_full    <= w_nxt;
      s_AWREADY <= ~aw_nxt;
      s_WREADY  <= ~w_nxt;
      if (s_AWVALID & s_AWREADY) begin
        aw_idx <= wa_idx;
        aw_ok  <= wa_ok;
      end
      if (s_WVALID & s_WREADY) begin
        w_data <= s_WDATA;
        w_strb <= s_WSTRB;
      end
      if (commit) begin
        s_BVALID <= 1'b1;
        s_BRESP  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_BREADY) s_BVALID <= 1'b0;
      if (commit & aw_ok)
        for (int b = 0; b < SW; b++)
          if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
    end
  // read samples regs before any same-edge commit lands, so it returns the pre-write value
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      s_ARREADY <= 1'b0;
      s_RVALID  <= 1'b0;
      s_RDATA   <= '0;
      s_RRESP   <= RESP_OKAY;
    end else if (s_ARVALID & s_ARREADY) begin
      s_ARREADY <= 1'b0;
      s_RVALID  <= 1'b1;
      s_RDATA   <= ra_ok ? regs[ra_idx] : '0;
      s_RRESP   <= ra_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      s_ARREADY <= ~s_RVALID | s_RREADY;
      if (s_RREADY) s_RVALID <= 1'b0;
    end
`ifdef AXI4_LITE_REGFILE_WR_PULSE_EN
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) wr_pulse <= '0;
    else wr_pulse <= (commit & aw_ok) ? NUM_REGS'(1) << aw_idx : '0;
`endif
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb_axi4_lite_slave_regfile: self-checking bench for axi4_lite_slave_regfile (32-bit, 16 regs, base 0).
module tb_axi4_lite_slave_regfile;
  logic iCLK = 1'b0, iRST = 1'b1;
  logic s_AWVALID = 0, s_AWREADY, s_WVALID = 0, s_WREADY, s_BVALID, s_BREADY = 0;
  logic s_ARVALID = 0, s_ARREADY, s_RVALID, s_RREADY = 0;
  logic [31:0] s_AWADDR = 0, s_ARADDR = 0, s_WDATA = 0, s_RDATA;
  logic [3:0] s_WSTRB = 0;
  logic [2:0] s_AWPROT = 0, s_ARPROT = 0;
  logic [1:0] s_BRESP, s_RRESP;
  logic [511:0] regs_out;
  logic [31:0] model [16];
  int checks = 0, errors = 0;
`ifdef AXI4_LITE_REGFILE_WR_PULSE_EN
  logic [15:0] wr_pulse;
  int pulse_cnt = 0;
  always @(negedge iCLK) if (wr_pulse[1]) pulse_cnt++;
`endif

  axi4_lite_slave_regfile dut (
    .iCLK(iCLK), .iRST(iRST),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWPROT(s_AWPROT),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARPROT(s_ARPROT),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
`ifdef AXI4_LITE_REGFILE_WR_PULSE_EN
    .wr_pulse(wr_pulse),
`endif
    .regs_out(regs_out)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [511:0] flat();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = model[i];
    return r;
  endfunction

  function automatic bit ok_addr(input logic [31:0] a);
    return a < 32'd64;
  endfunction

  task automatic align();
    @(posedge iCLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    logic awf, wf, bv;
    resp = 'x;
    lat = -1;
    s_AWADDR = a; s_WDATA = d; s_WSTRB = s;
    s_AWVALID = 1; s_WVALID = 1; s_BREADY = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge iCLK);
      awf = s_AWVALID & s_AWREADY;
      wf = s_WVALID & s_WREADY;
      bv = s_BVALID;
      if (bv) begin resp = s_BRESP; lat = c; end
      align();
      if (awf) s_AWVALID = 0;
      if (wf) s_WVALID = 0;
      if (bv) break;
    end
    s_AWVALID = 0; s_WVALID = 0; s_BREADY = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic arf, rv;
    d = 'x;
    resp = 'x;
    s_ARADDR = a; s_ARVALID = 1; s_RREADY = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge iCLK);
      arf = s_ARVALID & s_ARREADY;
      rv = s_RVALID;
      if (rv) begin d = s_RDATA; resp = s_RRESP; end
      align();
      if (arf) s_ARVALID = 0;
      if (rv) break;
    end
    s_ARVALID = 0; s_RREADY = 0;
  endtask

  task automatic test_reset();
    #2 iRST = 0;
    for (int i = 0; i < 16; i++) model[i] = 0;
    repeat (3) @(posedge iCLK);
    #1 iRST = 1;
    @(negedge iCLK);
    checks++;
    if ({s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID, s_BRESP, s_RRESP, s_RDATA} !== '0 || regs_out !== '0) begin
      errors++;
      $display("FAIL reset_state: ready/valid %b%b%b%b%b regs_out %h required all zero",
               s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID, regs_out);
    end
    @(negedge iCLK);
    checks++;
    if ({s_AWREADY, s_WREADY, s_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b%b%b required 111", s_AWREADY, s_WREADY, s_ARREADY);
    end
    align();
  endtask

  task automatic test_write_read();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, resp, lat);
    model[1] = 32'hDEADBEEF;
    checks++;
    if (resp !== 2'b00 || lat !== 2) begin
      errors++;
      $display("FAIL write_basic: bresp %b latency %0d required 00 and 2", resp, lat);
    end
    checks++;
    if (regs_out[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_regs_out: got %h required DEADBEEF", regs_out[63:32]);
    end
    axi_read(32'h4, d, resp);
    checks++;
    if (d !== 32'hDEADBEEF || resp !== 2'b00) begin
      errors++;
      $display("FAIL read_basic: rdata %h rresp %b required DEADBEEF 00", d, resp);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    int lat;
    axi_write(32'h4, 32'h12345678, 4'b0011, resp, lat);
    model[1] = merge(model[1], 32'h12345678, 4'b0011);
    checks++;
    if (resp !== 2'b00 || regs_out[63:32] !== model[1]) begin
      errors++;
      $display("FAIL strobe_partial: bresp %b reg1 %h required 00 %h", resp, regs_out[63:32], model[1]);
    end
    axi_write(32'h4, 32'hFFFFFFFF, 4'b0000, resp, lat);
    checks++;
    if (resp !== 2'b00 || regs_out[63:32] !== 32'hDEAD5678) begin
      errors++;
      $display("FAIL strobe_zero: bresp %b reg1 %h required 00 DEAD5678", resp, regs_out[63:32]);
    end
  endtask

  task automatic test_ordering();
    for (int o = 0; o < 2; o++) begin
      logic [31:0] d = $urandom;
      int r = $urandom_range(0, 15);
      int stalls = 0;
      if (o == 0) begin s_WDATA = d; s_WSTRB = 4'hF; s_WVALID = 1; end
      else begin s_AWADDR = r * 4; s_AWVALID = 1; end
      align();
      s_WVALID = 0; s_AWVALID = 0;
      repeat (3) begin
        @(negedge iCLK);
        if ((o == 0 ? s_WREADY : s_AWREADY) === 1'b0 && s_BVALID === 1'b0) stalls++;
        align();
      end
      checks++;
      if (stalls !== 3) begin
        errors++;
        $display("FAIL order%0d_hold: stalled cycles %0d required 3", o, stalls);
      end
      if (o == 0) begin s_AWADDR = r * 4; s_AWVALID = 1; end
      else begin s_WDATA = d; s_WSTRB = 4'hF; s_WVALID = 1; end
      align();
      s_WVALID = 0; s_AWVALID = 0;
      model[r] = d;
      @(negedge iCLK);
      checks++;
      if (s_BVALID !== 1'b0) begin
        errors++;
        $display("FAIL order%0d_early: bvalid %b required 0", o, s_BVALID);
      end
      @(negedge iCLK);
      checks++;
      if (s_BVALID !== 1'b1 || s_BRESP !== 2'b00 || regs_out !== flat()) begin
        errors++;
        $display("FAIL order%0d_commit: bvalid %b bresp %b reg%0d %h required 1 00 %h",
                 o, s_BVALID, s_BRESP, r, regs_out[32*r +: 32], d);
      end
      s_BREADY = 1;
      align();
      s_BREADY = 0;
    end
  endtask

  task automatic test_error();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    axi_write(32'h40, $urandom, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b10 || regs_out !== flat()) begin
      errors++;
      $display("FAIL err_write: bresp %b regs_out changed=%0d required 10 and unchanged", resp, regs_out !== flat());
    end
    axi_read(32'h40, d, resp);
    checks++;
    if (d !== 32'h0 || resp !== 2'b10) begin
      errors++;
      $display("FAIL err_read: rdata %h rresp %b required 0 10", d, resp);
    end
    axi_read(32'h7, d, resp);
    checks++;
    if (d !== model[1] || resp !== 2'b00) begin
      errors++;
      $display("FAIL unaligned_read: rdata %h rresp %b required %h 00", d, resp, model[1]);
    end
  endtask

  task automatic test_backpressure();
    int a1 = $urandom_range(0, 15), a2 = $urandom_range(0, 15);
    logic [31:0] d1 = $urandom, d2 = $urandom, held;
    int stable = 0;
    s_AWADDR = a1 * 4; s_WDATA = d1; s_WSTRB = 4'hF; s_AWVALID = 1; s_WVALID = 1;
    align();
    s_AWVALID = 0; s_WVALID = 0;
    align();
    model[a1] = d1;
    s_AWADDR = a2 * 4; s_WDATA = d2; s_AWVALID = 1; s_WVALID = 1;
    align();
    s_AWVALID = 0; s_WVALID = 0;
    repeat (5) begin
      @(negedge iCLK);
      if (s_BVALID === 1 && s_BRESP === 2'b00 && s_AWREADY === 0 && s_WREADY === 0 && regs_out === flat()) stable++;
      align();
    end
    checks++;
    if (stable !== 5) begin
      errors++;
      $display("FAIL bp_b_stable: stable cycles %0d required 5", stable);
    end
    s_BREADY = 1;
    align();
    s_BREADY = 0;
    @(negedge iCLK);
    checks++;
    if (s_BVALID !== 1'b0) begin
      errors++;
      $display("FAIL bp_b_drop: bvalid %b required 0", s_BVALID);
    end
    model[a2] = d2;
    @(negedge iCLK);
    checks++;
    if (s_BVALID !== 1'b1 || regs_out !== flat()) begin
      errors++;
      $display("FAIL bp_second_commit: bvalid %b reg%0d %h required 1 %h", s_BVALID, a2, regs_out[32*a2 +: 32], d2);
    end
    s_BREADY = 1;
    align();
    s_BREADY = 0;
    s_ARADDR = a2 * 4; s_ARVALID = 1;
    align();
    s_ARVALID = 0;
    stable = 0;
    repeat (4) begin
      @(negedge iCLK);
      held = s_RDATA;
      if (s_RVALID === 1 && s_ARREADY === 0 && held === model[a2] && s_RRESP === 2'b00) stable++;
      align();
    end
    checks++;
    if (stable !== 4) begin
      errors++;
      $display("FAIL bp_r_stable: stable cycles %0d required 4", stable);
    end
    s_RREADY = 1;
    align();
    s_RREADY = 0;
    @(negedge iCLK);
    checks++;
    if (s_RVALID !== 1'b0 || s_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL bp_r_release: rvalid %b arready %b required 0 1", s_RVALID, s_ARREADY);
    end
    align();
  endtask

  task automatic test_simultaneous();
    int r = $urandom_range(0, 15);
    logic [31:0] d = $urandom, old = model[r];
    s_AWADDR = r * 4; s_WDATA = d; s_WSTRB = 4'hF; s_AWVALID = 1; s_WVALID = 1;
    align();
    s_AWVALID = 0; s_WVALID = 0;
    s_ARADDR = r * 4; s_ARVALID = 1;
    align();
    s_ARVALID = 0;
    model[r] = d;
    @(negedge iCLK);
    checks++;
    if (s_RVALID !== 1 || s_RDATA !== old || s_BVALID !== 1 || regs_out !== flat()) begin
      errors++;
      $display("FAIL same_edge_read: rvalid %b rdata %h bvalid %b required 1 %h 1 (new %h)", s_RVALID, s_RDATA, s_BVALID, old, d);
    end
    s_RREADY = 1; s_BREADY = 1;
    align();
    s_RREADY = 0; s_BREADY = 0;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a = $urandom_range(0, 79), d = $urandom, rd;
      logic [3:0] s = 4'($urandom);
      logic [1:0] resp;
      int lat;
      if ($urandom_range(0, 1)) begin
        axi_write(a, d, s, resp, lat);
        if (ok_addr(a)) model[a / 4] = merge(model[a / 4], d, s);
        checks++;
        if (resp !== (ok_addr(a) ? 2'b00 : 2'b10) || regs_out !== flat()) begin
          errors++;
          bad++;
          if (bad < 5) $display("FAIL rand_write: addr %h bresp %b expected ok=%0d regs match=%0d", a, resp, ok_addr(a), regs_out === flat());
        end
      end else begin
        axi_read(a, rd, resp);
        checks++;
        if (rd !== (ok_addr(a) ? model[a / 4] : 32'h0) || resp !== (ok_addr(a) ? 2'b00 : 2'b10)) begin
          errors++;
          bad++;
          if (bad < 5) $display("FAIL rand_read: addr %h rdata %h rresp %b required %h", a, rd, resp, ok_addr(a) ? model[a / 4] : 32'h0);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    s_AWADDR = 32'h8; s_WDATA = 32'hA5A5A5A5; s_WSTRB = 4'hF; s_AWVALID = 1; s_WVALID = 1;
    s_ARADDR = 32'h4; s_ARVALID = 1;
    align();
    s_AWVALID = 0; s_WVALID = 0; s_ARVALID = 0;
    align();
    checks++;
    if (s_BVALID !== 1 || s_RVALID !== 1) begin
      errors++;
      $display("FAIL mid_setup: bvalid %b rvalid %b required 1 1", s_BVALID, s_RVALID);
    end
    #1 iRST = 0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = 0;
    checks++;
    if ({s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID, s_BRESP, s_RRESP, s_RDATA} !== '0 || regs_out !== '0) begin
      errors++;
      $display("FAIL mid_reset: bvalid %b rvalid %b rdata %h regs_out nonzero=%0d required all zero",
               s_BVALID, s_RVALID, s_RDATA, regs_out !== '0);
    end
    align();
    iRST = 1;
    @(negedge iCLK);
    checks++;
    if ({s_AWREADY, s_WREADY, s_ARREADY} !== 3'b000) begin
      errors++;
      $display("FAIL mid_release_early: ready %b%b%b required 000", s_AWREADY, s_WREADY, s_ARREADY);
    end
    @(negedge iCLK);
    checks++;
    if ({s_AWREADY, s_WREADY, s_ARREADY, s_BVALID} !== 4'b1110) begin
      errors++;
      $display("FAIL mid_release: ready %b%b%b bvalid %b required 1110", s_AWREADY, s_WREADY, s_ARREADY, s_BVALID);
    end
    align();
  endtask

`ifdef AXI4_LITE_REGFILE_WR_PULSE_EN
  task automatic test_wr_pulse();
    logic [1:0] resp;
    int lat;
    pulse_cnt = 0;
    axi_write(32'h4, $urandom, 4'hF, resp, lat);
    axi_write(32'h4, $urandom, 4'h0, resp, lat);
    axi_write(32'h44, $urandom, 4'hF, resp, lat);
    align();
    model[1] = regs_out[63:32];
    checks++;
    if (pulse_cnt !== 2 || wr_pulse !== '0) begin
      errors++;
      $display("FAIL wr_pulse: bit1 high cycles %0d pulse now %h required 2 and 0", pulse_cnt, wr_pulse);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_ordering();
    test_error();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_reset_mid();
`ifdef AXI4_LITE_REGFILE_WR_PULSE_EN
    test_wr_pulse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
